// File: rtl/note_player_pkg.sv
// Shared types and constants for the note player: widths, FSM states and the
// note-number to phase-step lookup table (55 Hz * 2^((n-1)/12), 2^22 phase, 48 kHz).
package note_player_pkg;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int STEP_W = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Entry 0 is a rest; entry 37 is A4 (440 Hz).
    localparam logic [STEP_W-1:0] STEP_TABLE [64] = '{
        20'd0,
        20'd4806,   20'd5092,   20'd5395,   20'd5715,   20'd6055,   20'd6415,
        20'd6797,   20'd7201,   20'd7629,   20'd8083,   20'd8563,   20'd9072,
        20'd9612,   20'd10184,  20'd10789,  20'd11431,  20'd12110,  20'd12830,
        20'd13593,  20'd14402,  20'd15258,  20'd16165,  20'd17127,  20'd18145,
        20'd19224,  20'd20367,  20'd21578,  20'd22861,  20'd24221,  20'd25661,
        20'd27187,  20'd28803,  20'd30516,  20'd32331,  20'd34253,  20'd36290,
        20'd38448,  20'd40734,  20'd43156,  20'd45722,  20'd48441,  20'd51322,
        20'd54373,  20'd57607,  20'd61032,  20'd64661,  20'd68506,  20'd72580,
        20'd76896,  20'd81468,  20'd86312,  20'd91445,  20'd96882,  20'd102643,
        20'd108747, 20'd115213, 20'd122064, 20'd129322, 20'd137012, 20'd145160,
        20'd153791, 20'd162936, 20'd172625
    };

endpackage

// File: rtl/dffr.sv
// Generic register with asynchronous active-low reset to a parameterised value.
module dffr #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= RESET_VAL;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/note_step_table.sv
// Combinational note-number to phase-step lookup.
module note_step_table
    import note_player_pkg::*;
(
    input  logic [NOTE_W-1:0] note_i,
    output logic [STEP_W-1:0] step_o
);

    assign step_o = STEP_TABLE[note_i];

endmodule

// File: rtl/note_player.sv
// Plays one note at a time: latches its phase step, counts down its duration in
// beats (frozen while paused) and pulses done_with_note for one cycle at the end.
module note_player
    import note_player_pkg::*;
#(
    parameter int NOTE_WIDTH = NOTE_W,
    parameter int DUR_WIDTH  = DUR_W,
    parameter int STEP_WIDTH = STEP_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play_enable,
    input  logic [NOTE_WIDTH-1:0] note_to_load,
    input  logic [DUR_WIDTH-1:0]  duration_to_load,
    input  logic                  load_new_note,
    input  logic                  beat,
    input  logic                  generate_next_sample,
    output logic [STEP_WIDTH-1:0] step_size,
    output logic                  generate_next,
    output logic                  note_active,
    output logic                  done_with_note
);

    state_e                state_q, state_d;
    logic [1:0]            state_bits_q;
    logic [DUR_WIDTH-1:0]  dur_q, dur_d;
    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic [STEP_WIDTH-1:0] table_step;

    note_step_table u_table (
        .note_i (note_to_load),
        .step_o (table_step)
    );

    dffr #(.WIDTH(2)) u_state_reg (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (2'(state_d)),
        .q_o   (state_bits_q)
    );

    dffr #(.WIDTH(DUR_WIDTH)) u_dur_reg (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (dur_d),
        .q_o   (dur_q)
    );

    dffr #(.WIDTH(STEP_WIDTH)) u_step_reg (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (step_d),
        .q_o   (step_q)
    );

    assign state_q = state_e'(state_bits_q);

    // A load wins in every state, including over a simultaneous beat.
    always_comb begin
        state_d = state_q;
        dur_d   = dur_q;
        step_d  = step_q;
        if (load_new_note) begin
            state_d = PLAY;
            dur_d   = duration_to_load;
            step_d  = table_step;
        end else begin
            case (state_q)
                PLAY: begin
                    if (play_enable) begin
                        if (dur_q == '0 || (beat && dur_q == DUR_WIDTH'(1))) begin
                            state_d = DONE;
                            dur_d   = '0;
                        end else if (beat) begin
                            dur_d = dur_q - DUR_WIDTH'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign step_size      = step_q;
    assign note_active    = (state_q == PLAY);
    assign done_with_note = (state_q == DONE);
    assign generate_next  = generate_next_sample & play_enable & (state_q == PLAY);

endmodule

// File: tb/tb_note_player.sv
// Randomised and directed bench for note_player against a beat-counting note model.
module tb_note_player;

    logic        clk = 1'b0;
    logic        reset;
    logic        play_enable;
    logic [5:0]  note_to_load;
    logic [5:0]  duration_to_load;
    logic        load_new_note;
    logic        beat;
    logic        generate_next_sample;
    logic [19:0] step_size;
    logic        generate_next;
    logic        note_active;
    logic        done_with_note;

    int checks   = 0;
    int failures = 0;
    int done_seen = 0;

    // Reference model: is a note sounding, beats still owed, end-of-note pulse.
    bit m_playing;
    bit m_done;
    int m_left;
    int m_step;

    note_player dut (
        .clk                  (clk),
        .reset                (reset),
        .play_enable          (play_enable),
        .note_to_load         (note_to_load),
        .duration_to_load     (duration_to_load),
        .load_new_note        (load_new_note),
        .beat                 (beat),
        .generate_next_sample (generate_next_sample),
        .step_size            (step_size),
        .generate_next        (generate_next),
        .note_active          (note_active),
        .done_with_note       (done_with_note)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_step(input int n);
        real f;
        if (n == 0) return 0;
        f = 55.0 * $pow(2.0, real'(n - 1) / 12.0) * 4194304.0 / 48000.0;
        return $rtoi(f + 0.5);
    endfunction

    task automatic model_reset();
        m_playing = 0;
        m_done    = 0;
        m_left    = 0;
        m_step    = 0;
    endtask

    task automatic model_step(input bit ld, input int note, input int dur, input bit en, input bit bt);
        if (ld) begin
            m_playing = 1;
            m_done    = 0;
            m_left    = dur;
            m_step    = ref_step(note);
        end else if (m_playing && en && (m_left == 0 || (bt && m_left == 1))) begin
            m_playing = 0;
            m_done    = 1;
            m_left    = 0;
        end else begin
            if (m_playing && en && bt) m_left = m_left - 1;
            m_done = 0;
        end
    endtask

    // One clock: drive at the falling edge, check outputs, then advance the model.
    task automatic cycle(input bit ld, input int note, input int dur,
                         input bit en, input bit bt, input bit gns);
        @(negedge clk);
        load_new_note        = ld;
        note_to_load         = 6'(note);
        duration_to_load     = 6'(dur);
        play_enable          = en;
        beat                 = bt;
        generate_next_sample = gns;
        #1;
        check("step_size", step_size, m_step);
        check("note_active", note_active, m_playing);
        check("done_with_note", done_with_note, m_done);
        check("generate_next", generate_next, gns & en & m_playing);
        if (done_with_note) done_seen++;
        @(posedge clk);
        model_step(ld, note, dur, en, bt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 1, 0, 1);
    endtask

    initial begin
        reset = 1'b0;
        load_new_note = 0; note_to_load = 0; duration_to_load = 0;
        play_enable = 0; beat = 0; generate_next_sample = 1;
        model_reset();
        #1;
        check("rst_step", step_size, 0);
        check("rst_active", note_active, 0);
        check("rst_done", done_with_note, 0);
        check("rst_gen", generate_next, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        // Basic note: A4, three beats.
        done_seen = 0;
        cycle(1, 37, 3, 1, 0, 1);
        #1 check("a4_step", step_size, 38448);
        idle(1);
        cycle(0, 0, 0, 1, 1, 1);
        idle(2);
        cycle(0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 1, 1, 1);
        #1 check("a4_done_after_3rd", done_with_note, 1);
        idle(3);
        check("a4_done_count", done_seen, 1);
        check("a4_idle_after", note_active, 0);
        check("a4_step_held", step_size, 38448);

        // Pause freezes the count and ignores beats.
        done_seen = 0;
        cycle(1, 20, 4, 1, 0, 1);
        cycle(0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, 1, 1);
            cycle(0, 0, 0, 0, 0, 1);
        end
        check("pause_no_done", done_seen, 0);
        check("pause_active", note_active, 1);
        cycle(0, 0, 0, 1, 1, 1);
        cycle(0, 0, 0, 1, 1, 1);
        #1 check("pause_not_yet", done_with_note, 0);
        cycle(0, 0, 0, 1, 1, 1);
        #1 check("pause_done_4th", done_with_note, 1);
        idle(2);
        check("pause_done_count", done_seen, 1);

        // Back-to-back load in the DONE cycle.
        cycle(1, 5, 1, 1, 0, 0);
        cycle(0, 0, 0, 1, 1, 0);
        #1 check("b2b_done", done_with_note, 1);
        cycle(1, 1, 2, 1, 0, 1);
        #1 check("b2b_active", note_active, 1);
        check("b2b_step", step_size, 4806);
        cycle(0, 0, 0, 1, 1, 1);
        cycle(0, 0, 0, 1, 1, 1);
        idle(2);

        // Load coincident with the final beat restarts without a pulse.
        done_seen = 0;
        cycle(1, 10, 1, 1, 0, 0);
        cycle(1, 22, 3, 1, 1, 0);
        #1 check("restart_no_done", done_with_note, 0);
        cycle(0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 1, 1, 0);
        #1 check("restart_still_on", note_active, 1);
        cycle(0, 0, 0, 1, 1, 0);
        #1 check("restart_done", done_with_note, 1);
        idle(2);
        check("restart_done_count", done_seen, 1);

        // Zero duration and rest note.
        cycle(1, 0, 0, 1, 0, 1);
        #1 check("zero_active", note_active, 1);
        check("rest_step", step_size, 0);
        cycle(0, 0, 0, 1, 0, 1);
        #1 check("zero_done", done_with_note, 1);
        cycle(1, 0, 2, 1, 0, 1);
        cycle(0, 0, 0, 1, 1, 1);
        cycle(0, 0, 0, 1, 1, 1);
        idle(2);

        // Asynchronous reset mid-note.
        done_seen = 0;
        cycle(1, 40, 10, 1, 0, 1);
        cycle(0, 0, 0, 1, 1, 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_step", step_size, 0);
        check("arst_active", note_active, 0);
        check("arst_done", done_with_note, 0);
        check("arst_gen", generate_next, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(4);
        check("arst_no_done", done_seen, 0);
        cycle(1, 37, 1, 1, 0, 1);
        #1 check("arst_reload", step_size, 38448);
        idle(2);

        // Every table entry.
        for (int n = 0; n < 64; n++) cycle(1, n, 5, 1, 0, 1);
        idle(2);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 9) == 0), $urandom_range(0, 63), $urandom_range(0, 7),
                  ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 1));
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 Parameters SHALL be, one per line:
- NOTE_WIDTH, 6, note number width; note 0 is a rest.
- DUR_WIDTH, 6, duration width, in beats.
- STEP_WIDTH, 20, phase step width presented to sine_reader.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- play_enable  in  1  high = playing; low = paused.
- note_to_load  in  NOTE_WIDTH  note number to play.
- duration_to_load  in  DUR_WIDTH  note length in beats.
- load_new_note  in  1  one-cycle pulse; captures note and duration.
- beat  in  1  one-cycle pulse, 48 per second.
- generate_next_sample  in  1  codec request for the next sample.
- step_size  out  STEP_WIDTH  registered phase step to sine_reader.
- generate_next  out  1  sample advance strobe to sine_reader.
- note_active  out  1  high while a note is sounding.
- done_with_note  out  1  one-cycle pulse when a note's duration expires.

Function
REQ-003 The FSM SHALL have three states: IDLE, PLAY, DONE.
REQ-004 In IDLE or DONE, load_new_note=1 SHALL go to PLAY next cycle, registering step_size=STEP_TABLE[note_to_load] and dur_count=duration_to_load.
REQ-005 In PLAY with play_enable=1 and beat=1, dur_count SHALL decrement by 1.
REQ-006 In PLAY, if dur_count==1 with a qualifying beat, or dur_count==0, the next state SHALL be DONE with dur_count=0.
REQ-007 DONE SHALL last exactly one cycle and assert done_with_note; it SHALL go to IDLE unless load_new_note=1, which SHALL go to PLAY (back-to-back notes, no gap cycle).
REQ-008 load_new_note in PLAY SHALL restart the note per REQ-004 with no done_with_note pulse; load SHALL take priority over a simultaneous beat.
REQ-009 play_enable=0 SHALL freeze dur_count and the state; beats while paused SHALL be ignored.
REQ-010 generate_next SHALL be combinational: generate_next_sample AND play_enable AND (state==PLAY); it SHALL be 0 in IDLE and DONE.
REQ-011 note_active SHALL be 1 exactly when state==PLAY.
REQ-012 Note 0 SHALL map to step_size 0 (rest); the note still times out normally.
REQ-013 Note n (1..63) SHALL map to round(55 * 2^((n-1)/12) * 2^22 / 48000); note 1 = 4806, note 37 (A4, 440 Hz) = 38448.
REQ-014 step_size SHALL hold its value through DONE and IDLE until the next load.
REQ-015 dur_count SHALL be unsigned DUR_WIDTH; it SHALL never wrap below 0.

Reset
REQ-016 reset low SHALL asynchronously force state=IDLE, dur_count=0, step_size=0, done_with_note=0, note_active=0.
REQ-017 Reset mid-note SHALL abandon the note with no done_with_note pulse; the first load after reset release SHALL behave per REQ-004.

Structure
REQ-018 A shared package SHALL hold the state enumeration, the NOTE/DUR/STEP width constants, and the 64-entry STEP_TABLE constant.
REQ-019 Lookup SHALL be one combinational sub-module, note_step_table (note in, step out); the FSM and counter SHALL live in note_player using the codebase dffr register.

Verification
REQ-020 Load note 37, duration 3, play_enable=1, 3 beats -> step_size=38448 one cycle after load; done_with_note pulses once on the cycle after the 3rd beat; state then IDLE.
REQ-021 Load duration 4, drop play_enable after 1 beat, send 5 beats, re-enable, send 3 beats -> done_with_note only after the 4th counted beat; generate_next=0 while paused.
REQ-022 Load during the DONE cycle (note 1, duration 2) -> no IDLE cycle; step_size=4806; note_active continuously high apart from the one DONE cycle.
REQ-023 load_new_note coincident with beat in PLAY, dur_count=1 -> no done_with_note; dur_count=new duration.
REQ-024 Duration 0 load -> DONE on the next cycle; note 0 -> step_size=0 with normal timing.
REQ-025 Assert reset mid-note -> all outputs 0 immediately without waiting for clk; no done_with_note pulse after release.
